// File: rtl/debug_uart_tx_pkg.sv
// Shared constants and types for the CPU debug port transmitter.
package debug_pkg;

    localparam int unsigned DEBUG_BYTES = 32;
    localparam logic [7:0]  SYNC_BYTE   = 8'hA5;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

endpackage

// File: rtl/debug_uart_tx_if.sv
// Debug port bundle between the CPU side and the UART transmitter.
interface debug_uart_tx_if;
    import debug_pkg::*;

    logic [8:DEBUG_BYTES*8-1] debug_port_vector;
    logic                     start;
    logic                     busy;
    logic                     frame_done;
    logic                     tx;

    modport master (
        output debug_port_vector,
        output start,
        input  busy,
        input  frame_done,
        input  tx
    );

    modport slave (
        input  debug_port_vector,
        input  start,
        output busy,
        output frame_done,
        output tx
    );

endinterface

// File: rtl/debug_uart_tx_byte.sv
// 8N1 byte serializer; a byte offered in the last stop cycle follows with no gap.
module uart_tx_byte
    import debug_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx
);

    localparam int unsigned    BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    tx_state_t      state, state_n;
    logic [BW-1:0]  baud_cnt, baud_n;
    logic [2:0]     bit_idx, bit_n;
    logic [7:0]     shreg, shreg_n;
    logic           tx_q, tx_n;
    logic           bit_end;

    always_ff @(posedge clk) begin
        if (nreset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            tx_q     <= 1'b1;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_idx  <= bit_n;
            shreg    <= shreg_n;
            tx_q     <= tx_n;
        end
    end

    always_comb begin
        state_n = state;
        baud_n  = baud_cnt;
        bit_n   = bit_idx;
        shreg_n = shreg;
        ready   = 1'b0;
        tx_n    = 1'b1;
        bit_end = (baud_cnt == BAUD_LAST);

        case (state)
            IDLE: begin
                ready = 1'b1;
                if (valid) begin
                    state_n = START;
                    baud_n  = '0;
                    shreg_n = data;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n = DATA;
                    baud_n  = '0;
                    bit_n   = '0;
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_n  = '0;
                    shreg_n = shreg >> 1;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                        bit_n   = '0;
                    end else begin
                        bit_n = bit_idx + 3'd1;
                    end
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    ready  = 1'b1;
                    baud_n = '0;
                    if (valid) begin
                        state_n = START;
                        shreg_n = data;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        // tx is registered from the next state so the line moves with the FSM
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shreg_n[0];
            default: tx_n = 1'b1;
        endcase
    end

    assign tx = tx_q;

endmodule

// File: rtl/debug_uart_tx.sv
// Debug port transmitter: snapshots the CPU debug vector and streams it as a
// SYNC_BYTE-led frame of DEBUG_BYTES UART bytes.
module debug_uart_tx
    import debug_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 104
) (
    input  logic             clk,
    input  logic             nreset,
    debug_uart_tx_if.slave   bus
);

    localparam int unsigned    BYW       = $clog2(DEBUG_BYTES);
    localparam logic [BYW-1:0] LAST_BYTE = BYW'(DEBUG_BYTES - 1);

    logic [8:DEBUG_BYTES*8-1] snap;
    logic [BYW-1:0]           byte_idx;
    logic                     busy_q;
    logic                     last_byte;
    logic                     valid;
    logic                     ready;
    logic [7:0]               data;
    logic                     frame_done;
    logic                     tx_line;

    always_comb begin
        valid      = 1'b0;
        data       = '0;
        last_byte  = (byte_idx == LAST_BYTE);
        // idle: start feeds the serializer directly so the sync byte leaves on the accept edge
        if (busy_q) begin
            valid = !last_byte;
            data  = snap[8:15];
        end else begin
            valid = bus.start;
            data  = SYNC_BYTE;
        end
        frame_done = busy_q && last_byte && ready;
    end

    always_ff @(posedge clk) begin
        if (nreset) begin
            busy_q   <= 1'b0;
            byte_idx <= '0;
            snap     <= '0;
        end else if (!busy_q) begin
            if (bus.start) begin
                busy_q   <= 1'b1;
                byte_idx <= '0;
                snap     <= bus.debug_port_vector;
            end
        end else if (frame_done) begin
            busy_q   <= 1'b0;
            byte_idx <= '0;
        end else if (valid && ready) begin
            byte_idx <= byte_idx + BYW'(1);
            snap     <= {snap[16:DEBUG_BYTES*8-1], 8'h00};
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk    (clk),
        .nreset (nreset),
        .data   (data),
        .valid  (valid),
        .ready  (ready),
        .tx     (tx_line)
    );

    assign bus.tx         = tx_line;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done;

endmodule

// File: tb/tb_debug_uart_tx.sv
// Bench for debug_uart_tx: host-side UART receiver checks bytes against a queue
// of expected values pushed when each frame is requested.
module tb_debug_uart_tx;
    import debug_pkg::*;

    localparam int CPB       = 4;
    localparam int FRAME_LEN = DEBUG_BYTES * 10 * CPB;

    logic clk = 1'b0;
    logic nreset = 1'b1;

    debug_uart_tx_if bus();

    debug_uart_tx #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    int         done_cnt = 0;
    int         frames_exp = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_frame(input logic [8:DEBUG_BYTES*8-1] v);
        exp_q.push_back(SYNC_BYTE);
        for (int k = 1; k < DEBUG_BYTES; k++) exp_q.push_back(v[k*8 +: 8]);
        frames_exp++;
    endtask

    // Leaves the bench on the negedge of the first start-bit cycle.
    task automatic send_frame(input logic [8:DEBUG_BYTES*8-1] v);
        @(negedge clk);
        bus.debug_port_vector = v;
        bus.start = 1'b1;
        push_frame(v);
        @(negedge clk);
        bus.start = 1'b0;
        check("lat_tx", bus.tx, 0);
        check("lat_busy", bus.busy, 1);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (bus.frame_done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (bus.frame_done !== 1'b1) check("done_timeout", 0, 1);
    endtask

    // Mid-bit check of the raw line for the first nbytes; byte i is seq[i*8 +: 8].
    task automatic check_line(input logic [39:0] seq, input int nbytes, input string tag);
        logic [7:0] bv;
        int         n;
        logic       e;
        for (int t = 0; t < nbytes * 10 * CPB; t++) begin
            if (t % CPB == CPB / 2) begin
                bv = seq[(t / (10 * CPB)) * 8 +: 8];
                n  = (t % (10 * CPB)) / CPB;
                e  = (n == 0) ? 1'b0 : (n == 9) ? 1'b1 : bv[n-1];
                check(tag, bus.tx, e);
            end
            @(negedge clk);
        end
    endtask

    function automatic logic [8:DEBUG_BYTES*8-1] rand_vec();
        logic [8:DEBUG_BYTES*8-1] v;
        for (int k = 1; k < DEBUG_BYTES; k++) v[k*8 +: 8] = 8'($urandom);
        return v;
    endfunction

    // Host receiver and frame-length monitor.
    initial begin
        bit         rx_active = 0;
        bit         in_frame = 0;
        int         rx_t = 0;
        int         fcnt = 0;
        int         n;
        logic [7:0] rx_byte = '0;
        forever begin
            @(negedge clk);
            if (nreset) begin
                rx_active = 0;
                in_frame  = 0;
            end else begin
                if (in_frame) fcnt++;
                else if (bus.tx === 1'b0) begin
                    in_frame = 1;
                    fcnt = 1;
                end
                if (bus.frame_done === 1'b1) begin
                    done_cnt++;
                    check("frame_len", in_frame ? fcnt : 0, FRAME_LEN);
                    in_frame = 0;
                end
                if (rx_active) rx_t++;
                else if (bus.tx === 1'b0) begin
                    rx_active = 1;
                    rx_t = 0;
                end
                if (rx_active && (rx_t % CPB == CPB / 2)) begin
                    n = rx_t / CPB;
                    if (n == 0) check("rx_start", bus.tx, 0);
                    else if (n <= 8) rx_byte[n-1] = bus.tx;
                    else begin
                        check("rx_stop", bus.tx, 1);
                        if (exp_q.size() == 0) check("rx_extra", rx_byte, 9'h100);
                        else check("rx_byte", rx_byte, exp_q.pop_front());
                        rx_active = 0;
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=%0d exp=%0d", total, 0);
        $fatal(1, "global timeout");
    end

    initial begin
        logic [8:DEBUG_BYTES*8-1] v;
        int                       d0;
        int                       g;

        bus.start = 1'b1;
        bus.debug_port_vector = rand_vec();

        // Reset held with start high
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_tx", bus.tx, 1);
            check("rst_busy", bus.busy, 0);
            check("rst_done", bus.frame_done, 0);
        end
        nreset = 1'b0;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_tx", bus.tx, 1);
        check("idle_busy", bus.busy, 0);

        // Sync byte and first data bytes on the line
        v = '0;
        v[4*8 +: 8] = 8'h04;
        send_frame(v);
        check_line({8'h04, 8'h00, 8'h00, 8'h00, SYNC_BYTE}, 5, "line_bit");
        wait_done(FRAME_LEN + 100);

        // Snapshot: vector changes right after acceptance
        repeat (3) @(negedge clk);
        send_frame(rand_vec());
        bus.debug_port_vector = '1;
        wait_done(FRAME_LEN + 100);

        // start while busy is ignored
        repeat (9) @(negedge clk);
        d0 = done_cnt;
        send_frame(rand_vec());
        repeat (488) @(negedge clk);
        bus.debug_port_vector = rand_vec();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(FRAME_LEN + 100);
        repeat (300) @(negedge clk);
        check("one_frame", done_cnt - d0, 1);
        check("post_busy", bus.busy, 0);
        check("post_tx", bus.tx, 1);

        // start held high: frames separated by one idle cycle
        d0 = done_cnt;
        v = rand_vec();
        @(negedge clk);
        bus.debug_port_vector = v;
        bus.start = 1'b1;
        for (int f = 0; f < 3; f++) push_frame(v);
        @(negedge clk);
        check("held_lat_tx", bus.tx, 0);
        for (int f = 0; f < 3; f++) begin
            wait_done(FRAME_LEN + 100);
            if (f == 2) bus.start = 1'b0;
            else begin
                g = 0;
                @(negedge clk);
                check("gap_busy", bus.busy, 0);
                while (bus.tx === 1'b1 && g < 8) begin
                    g++;
                    @(negedge clk);
                end
                check("idle_gap", g, 1);
            end
        end
        repeat (20) @(negedge clk);
        check("held_frames", done_cnt - d0, 3);

        // Reset during byte 5, data bit 3
        send_frame(rand_vec());
        repeat (5 * 10 * CPB + 4 * CPB + 1) @(negedge clk);
        nreset = 1'b1;
        exp_q.delete();
        frames_exp--;
        @(negedge clk);
        check("abort_tx", bus.tx, 1);
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.frame_done, 0);
        @(negedge clk);
        nreset = 1'b0;
        repeat (2) @(negedge clk);
        send_frame(rand_vec());
        check_line({32'h0, SYNC_BYTE}, 1, "restart_bit");
        wait_done(FRAME_LEN + 100);

        // Random frames
        for (int f = 0; f < 20; f++) begin
            repeat ($urandom_range(0, 4)) @(negedge clk);
            send_frame(rand_vec());
            wait_done(FRAME_LEN + 100);
        end

        repeat (10) @(negedge clk);
        check("q_empty", exp_q.size(), 0);
        check("done_total", done_cnt, frames_exp);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/debug_uart_tx.md
Name: debug_uart_tx

Overview:
- Transmit side of the CPU debug port.
- On a start pulse, takes a snapshot of the CPU's debug_port_vector and sends it to the host as one framed burst of DEBUG_BYTES UART bytes (8N1).
- Byte 0 is a fixed sync byte; bytes 1..DEBUG_BYTES-1 come from the vector.
- Sits in the top level between the cpu instance and the FPGA TX pin.

Parameters:
- CLKS_PER_BIT, 104, clk cycles per UART bit (12 MHz / 115200).
- DEBUG_BYTES, 32, bytes per frame including the sync byte.
- SYNC_BYTE, 8'hA5, value sent as byte 0 of every frame.

Ports:
- clk  input  1  system clock
- nreset  input  1  reset; synchronous, active-high
- debug_port_vector  input  [8:DEBUG_BYTES*8-1]  CPU debug data; byte k = bits [k*8 : k*8+7], bit k*8 is the MSB
- start  input  1  request one frame; sampled only when idle
- busy  output  1  high from the cycle after an accepted start until the cycle after frame_done
- frame_done  output  1  one-cycle pulse on the last cycle of the final stop bit
- tx  output  1  UART line, idles high

Behaviour:
- Reset: nreset is synchronous, active-high. While it is asserted: tx=1, busy=0, frame_done=0, FSM=IDLE, all counters=0. Reset mid-frame aborts the frame; tx=1 on the next edge and no partial byte is completed.
- Snapshot: when start=1 in IDLE, the vector is captured into a shadow register of (DEBUG_BYTES-1)*8 bits. Vector changes after that edge do not affect the frame.
- Byte order: SYNC_BYTE first, then bytes 1, 2, ..., DEBUG_BYTES-1.
- Bit order: each byte is sent LSB first, so for byte k, bit k*8+7 goes out first.
- FSM: IDLE -> START -> DATA -> STOP -> (START or IDLE).
  - IDLE: tx=1. An accepted start enters START on the next edge.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: tx = current data bit, CLKS_PER_BIT cycles per bit, 8 bits (bit_idx 0..7), then STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. If byte_idx < DEBUG_BYTES-1: increment byte_idx and go to START. Otherwise pulse frame_done on the last STOP cycle and go to IDLE.
- Latency: start sampled at edge N gives tx=0 and busy=1 after edge N+1. Frame length is exactly DEBUG_BYTES*10*CLKS_PER_BIT cycles. Bytes within a frame are back-to-back with no gap.
- Counters:
  - baud_cnt: 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT).
  - bit_idx: 3 bits.
  - byte_idx: $clog2(DEBUG_BYTES) bits.
  - All wrap or clear on the transition that leaves their state.
- start while busy: ignored, not queued. start in the frame_done cycle is also ignored. busy drops on the following edge, and a start there is accepted. Holding start high therefore yields frames separated by exactly one IDLE cycle.
- No combinational path from any input to tx; tx is registered.

Decomposition:
- Package debug_pkg:
  - DEBUG_BYTES constant, shared with cpu and top.
  - SYNC_BYTE constant.
  - tx_state_t enum {IDLE, START, DATA, STOP}.
- Sub-module uart_tx_byte: byte serializer with an 8-bit data input, valid/ready handshake, tx output, and a CLKS_PER_BIT parameter.
- debug_uart_tx keeps the snapshot register, byte sequencing, busy, and frame_done, and feeds uart_tx_byte one byte per ready.

Test Plan (CLKS_PER_BIT=4, DEBUG_BYTES=32):
- Reset: hold nreset=1 for 3 cycles with start=1 -> tx=1, busy=0, frame_done=0 throughout.
- Sync byte: release reset, pulse start with bytes 1..4 = 00 00 00 04 -> tx holds each bit for 4 cycles: 0, 1,0,1,0,0,1,0,1, 1; then 0x00, 0x00, 0x00, then 0x04 as data bits 0,0,1,0,0,0,0,0.
- Snapshot and timing: pulse start, then change the whole vector to 0xFF next cycle -> received bytes equal the pre-change values; frame_done pulses exactly 1280 cycles after tx first goes low.
- start while busy: pulse start at cycles 10 and 500 -> exactly one frame is sent. With start held high continuously -> frames repeat with exactly one idle cycle (tx=1) between the last stop bit and the next start bit.
- Reset mid-frame: assert nreset during byte 5, bit 3 -> tx=1 and busy=0 on the next edge. After release plus a new start, the frame restarts from SYNC_BYTE 0xA5.
- Bench model: a host-side UART receiver checks all 32 bytes against the captured vector with a random vector, over 20 frames.
